// File: rtl/btn_pkg.sv
// Shared types and default timing for push-button conditioners.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   // 10 ms debounce and 0.5 s auto-repeat at 50 MHz
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_REPEAT_CYCLES   = 25000000;

endpackage

// File: rtl/sync_ff_chain.sv
// Parameterised flop chain for bringing an asynchronous level into the clock domain.
module sync_ff_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_debounce_one_shot.sv
// Button synchroniser + debounce FSM emitting one pulse per accepted press.
// Optional auto-repeat while held: define BTN_AUTOREPEAT_EN.
//
// state        | meaning
// IDLE         | button released and stable
// PRESS_WAIT   | sync high, counting stable cycles before accepting press
// HELD         | press accepted, button still down
// RELEASE_WAIT | sync low, counting stable cycles before accepting release
module btn_debounce_one_shot
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_raw,
   output logic o_btn_pulse,
   output logic o_btn_level,
   output logic o_busy
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   generate
      if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
         $error("btn_debounce_one_shot: SYNC_STAGES, DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
      end
   endgenerate

   logic             sync;
   btn_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             cnt_done;
   logic             pulse_nxt, level_nxt;

   sync_ff_chain #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(i_clk),
      .rst(i_rst),
      .d  (i_btn_raw),
      .q  (sync)
   );

   assign cnt_done = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
   assign o_busy   = (state == PRESS_WAIT) || (state == RELEASE_WAIT);

`ifdef BTN_AUTOREPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_CYCLES);

   logic [RPT_W-1:0] rpt, rpt_nxt;
   logic             rpt_done;

   assign rpt_done = (rpt == RPT_W'(REPEAT_CYCLES - 1));
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pulse_nxt = 1'b0;
      level_nxt = o_btn_level;
`ifdef BTN_AUTOREPEAT_EN
      rpt_nxt   = rpt;
`endif
      case (state)
         IDLE: begin
`ifdef BTN_AUTOREPEAT_EN
            rpt_nxt = '0;
`endif
            if (sync) begin
               state_nxt = PRESS_WAIT;
               cnt_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sync) begin
               state_nxt = IDLE;
            end else if (cnt_done) begin
               state_nxt = HELD;
               pulse_nxt = 1'b1;
               level_nxt = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
               rpt_nxt   = '0;
`endif
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (!sync) begin
               state_nxt = RELEASE_WAIT;
               cnt_nxt   = '0;
`ifdef BTN_AUTOREPEAT_EN
            end else if (rpt_done) begin
               pulse_nxt = 1'b1;
               rpt_nxt   = '0;
            end else begin
               rpt_nxt = rpt + RPT_W'(1);
`endif
            end
         end
         RELEASE_WAIT: begin
            // repeat counter deliberately frozen here so a release bounce resumes the cadence
            if (sync) begin
               state_nxt = HELD;
            end else if (cnt_done) begin
               state_nxt = IDLE;
               level_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         o_btn_pulse <= 1'b0;
         o_btn_level <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         o_btn_pulse <= pulse_nxt;
         o_btn_level <= level_nxt;
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rpt <= '0;
      end else begin
         rpt <= rpt_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_btn_debounce_one_shot.sv
// Scoreboard bench for btn_debounce_one_shot (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
module tb_btn_debounce_one_shot;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic raw = 1'b0;
   logic pulse, level, busy;

   int edge_n = 0;
   int checks = 0;
   int errors = 0;
   int base;

   int   exp_pulse_q[$];
   int   exp_lvl_edge_q[$];
   logic exp_lvl_val_q[$];
   logic prev_level = 1'b0;

   btn_debounce_one_shot #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_CYCLES  (8)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_btn_raw  (raw),
      .o_btn_pulse(pulse),
      .o_btn_level(level),
      .o_busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // monitor: every pulse and every level change must match the head of its queue
   always @(negedge clk) begin : monitor
      int   e;
      logic v;
      if (pulse === 1'b1) begin
         checks++;
         if (exp_pulse_q.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected: pulse seen after edge %0d, none expected", edge_n);
         end else begin
            e = exp_pulse_q.pop_front();
            if (e != edge_n) begin
               errors++;
               $display("FAIL pulse_edge: pulse after edge %0d, expected after edge %0d", edge_n, e);
            end
         end
      end
      if (level !== prev_level) begin
         checks++;
         if (exp_lvl_edge_q.size() == 0) begin
            errors++;
            $display("FAIL level_unexpected: level went %b after edge %0d, no change expected", level, edge_n);
         end else begin
            e = exp_lvl_edge_q.pop_front();
            v = exp_lvl_val_q.pop_front();
            if (e != edge_n || v !== level) begin
               errors++;
               $display("FAIL level_change: level %b after edge %0d, expected %b after edge %0d",
                        level, edge_n, v, e);
            end
         end
      end
      prev_level <= level;
   end

   task automatic hold(input logic v, input int n);
      raw = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_pulse(input int e);
      exp_pulse_q.push_back(e);
   endtask

   task automatic expect_level(input int e, input logic v);
      exp_lvl_edge_q.push_back(e);
      exp_lvl_val_q.push_back(v);
   endtask

   task automatic check_val(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_pulse_q.size() != 0 || exp_lvl_edge_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing: %0d pulses and %0d level changes outstanding, expected 0 and 0",
                  name, exp_pulse_q.size(), exp_lvl_edge_q.size());
         exp_pulse_q.delete();
         exp_lvl_edge_q.delete();
         exp_lvl_val_q.delete();
      end
   endtask

   initial begin
      rst = 1'b1;
      raw = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_pulse", pulse, 1'b0);
      check_val("reset_level", level, 1'b0);
      check_val("reset_busy", busy, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // clean press and release
      base = edge_n;
      expect_pulse(base + 7);
`ifdef BTN_AUTOREPEAT_EN
      expect_pulse(base + 15);
`endif
      expect_level(base + 7, 1'b1);
      hold(1'b1, 20);
      base = edge_n;
      expect_level(base + 7, 1'b0);
      hold(1'b0, 12);
      check_drained("clean_press");

      // single-cycle glitch: busy for exactly one cycle, nothing else
      base = edge_n;
      hold(1'b1, 1);
      raw = 1'b0;
      check_val("glitch_busy", busy, 1'b0);
      for (int k = 2; k <= 7; k++) begin
         @(negedge clk);
         check_val("glitch_busy", busy, k == 3);
      end
      check_val("glitch_level", level, 1'b0);
      hold(1'b0, 4);
      check_drained("glitch");

      // press bounce: 1,1,1,0 then stable
      base = edge_n;
      expect_pulse(base + 11);
      expect_level(base + 11, 1'b1);
      hold(1'b1, 3);
      hold(1'b0, 1);
      hold(1'b1, 10);
      base = edge_n;
      expect_level(base + 7, 1'b0);
      hold(1'b0, 12);
      check_drained("press_bounce");

      // release bounce while held
      base = edge_n;
      expect_pulse(base + 7);
      expect_level(base + 7, 1'b1);
      hold(1'b1, 10);
      hold(1'b0, 2);
      hold(1'b1, 3);
      check_val("release_bounce_level", level, 1'b1);
      base = edge_n;
      expect_level(base + 7, 1'b0);
      hold(1'b0, 12);
      check_drained("release_bounce");

      // reset lands on the acceptance edge of a press
      base = edge_n;
      hold(1'b1, 6);
      check_val("pre_reset_busy", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_val("mid_reset_pulse", pulse, 1'b0);
      check_val("mid_reset_level", level, 1'b0);
      check_val("mid_reset_busy", busy, 1'b0);
      @(negedge clk);
      check_val("mid_reset_pulse", pulse, 1'b0);
      rst = 1'b0;
      base = edge_n;
      expect_pulse(base + 7);
      expect_level(base + 7, 1'b1);
      hold(1'b1, 10);
      base = edge_n;
      expect_level(base + 7, 1'b0);
      hold(1'b0, 12);
      check_drained("reset_mid_press");

      // long hold
      base = edge_n;
      expect_pulse(base + 7);
`ifdef BTN_AUTOREPEAT_EN
      expect_pulse(base + 15);
      expect_pulse(base + 23);
      expect_pulse(base + 31);
      expect_pulse(base + 39);
`endif
      expect_level(base + 7, 1'b1);
      hold(1'b1, 40);
      base = edge_n;
      expect_level(base + 7, 1'b0);
      hold(1'b0, 12);
      check_drained("long_hold");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
